// File: rtl/ib_pkg.sv
// Constants and loader FSM encoding shared by the instruction buffer
// and the loader that fills it.
package ib_pkg;
  localparam int PC_DEPTH_DEF    = 1024;
  localparam int ADDR_BITS_DEF   = 32;
  localparam int INST_BITS_DEF   = 128;
  localparam int S_DATA_BITS_DEF = 32;

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} loader_state_t;
endpackage

// File: rtl/inst_beat_packer.sv
// Assembles INST_BITS-wide instructions from S_DATA_BITS stream beats.
// The first beat lands in the LSBs.
module inst_beat_packer #(
  parameter int INST_BITS   = 128,
  parameter int S_DATA_BITS = 32,
  localparam int BEATS      = INST_BITS / S_DATA_BITS,
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   beat,
  input  logic [S_DATA_BITS-1:0] s_tdata,
  output logic [CNT_W-1:0]       beat_cnt,
  output logic                   last_beat,
  output logic [INST_BITS-1:0]   word
);
  logic [INST_BITS-1:0] acc;

  assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      beat_cnt <= '0;
      acc      <= '0;
    end else if (beat) begin
      acc[beat_cnt*S_DATA_BITS +: S_DATA_BITS] <= s_tdata;
      beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
    end
  end

  // The final beat is folded in combinationally so the word is complete on its handshake.
  generate
    if (BEATS == 1) begin : g_single
      assign word = s_tdata;
    end else begin : g_multi
      assign word = {s_tdata, acc[INST_BITS-S_DATA_BITS-1:0]};
    end
  endgenerate
endmodule

// File: rtl/instruction_loader.sv
// Streams instructions from a host AXI4-Stream into the instruction buffer BRAM.
// One write bubble per instruction; done pulse and sticky error per load.
module instruction_loader
  import ib_pkg::*;
#(
  parameter int PC_DEPTH    = PC_DEPTH_DEF,
  parameter int ADDR_BITS   = ADDR_BITS_DEF,
  parameter int INST_BITS   = INST_BITS_DEF,
  parameter int S_DATA_BITS = S_DATA_BITS_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load_start,
  input  logic [ADDR_BITS-1:0]   load_base,
  input  logic [ADDR_BITS-1:0]   load_count,
  input  logic [S_DATA_BITS-1:0] s_tdata,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic                   wea,
  output logic [ADDR_BITS-1:0]   addra,
  output logic [INST_BITS-1:0]   dina,
  output logic                   busy,
  output logic                   load_done,
  output logic                   load_err,
  output logic [ADDR_BITS-1:0]   last_addr
);
  localparam int BEATS = INST_BITS / S_DATA_BITS;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  loader_state_t state, next;
  logic                 start_q, start_edge;
  logic [ADDR_BITS-1:0] base, count, inst_idx;
  logic [ADDR_BITS:0]   end_ext;
  logic                 overflow, hs, last_beat, final_inst, early_last;
  logic [CNT_W-1:0]     beat_cnt;
  logic [INST_BITS-1:0] word;

  assign start_edge = load_start & ~start_q;
  assign end_ext    = {1'b0, load_base} + {1'b0, load_count};
  assign overflow   = end_ext > (ADDR_BITS+1)'(PC_DEPTH);
  assign hs         = s_tvalid & s_tready;
  assign final_inst = (inst_idx == count - 1'b1);
  assign early_last = hs & s_tlast & ~(last_beat & final_inst);

  inst_beat_packer #(.INST_BITS(INST_BITS), .S_DATA_BITS(S_DATA_BITS)) u_packer (
    .clk(clk), .reset_n(reset_n), .clear(state != RECV), .beat(hs),
    .s_tdata(s_tdata), .beat_cnt(beat_cnt), .last_beat(last_beat), .word(word)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:  if (start_edge) next = (load_count == '0 || overflow) ? DONE : RECV;
      RECV:  if (early_last) next = DONE;
             else if (hs && last_beat) next = WRITE;
      WRITE: next = final_inst ? DONE : RECV;
      DONE:  next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    s_tready  = 1'b0;
    wea       = 1'b0;
    load_done = 1'b0;
    busy      = (state != IDLE);
    case (state)
      RECV:  s_tready  = 1'b1;
      WRITE: wea       = 1'b1;
      DONE:  load_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      start_q   <= 1'b0;
      base      <= '0;
      count     <= '0;
      inst_idx  <= '0;
      addra     <= '0;
      dina      <= '0;
      last_addr <= '0;
      load_err  <= 1'b0;
    end else begin
      start_q <= load_start;
      case (state)
        IDLE: if (start_edge) begin
          base      <= load_base;
          count     <= load_count;
          inst_idx  <= '0;
          last_addr <= (load_count == '0) ? '0 : load_base + load_count - 1'b1;
          // A zero-length load is never an error, even with an out-of-range base.
          load_err  <= (load_count != '0) && overflow;
        end
        RECV: begin
          if (early_last) begin
            load_err <= 1'b1;
          end else if (hs && last_beat) begin
            dina  <= word;
            addra <= base + inst_idx;
            if (final_inst && !s_tlast) load_err <= 1'b1;
          end
        end
        WRITE: if (!final_inst) inst_idx <= inst_idx + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_loader.sv
// Randomized bench for instruction_loader against a transaction-level model
// of what each load should write, report and consume.
module tb_instruction_loader;
  localparam int BEATS = 4;
  localparam int DEPTH = 1024;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         load_start = 1'b0;
  logic [31:0]  load_base = '0, load_count = '0;
  logic [31:0]  s_tdata = '0;
  logic         s_tvalid = 1'b0, s_tlast = 1'b0;
  logic         s_tready, wea, busy, load_done, load_err;
  logic [31:0]  addra, last_addr;
  logic [127:0] dina;

  instruction_loader dut (
    .clk(clk), .reset_n(reset_n), .load_start(load_start), .load_base(load_base),
    .load_count(load_count), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .wea(wea), .addra(addra), .dina(dina), .busy(busy),
    .load_done(load_done), .load_err(load_err), .last_addr(last_addr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {logic [31:0] a; logic [127:0] d; int c;} wr_t;

  // observed activity
  int  cyc = 0;
  wr_t got_q[$];
  int  done_n, done_cyc, tready_seen;
  bit  tready_bad;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (reset_n) begin
    if (wea) got_q.push_back('{addra, dina, cyc});
    if (load_done) begin done_n++; done_cyc = cyc; end
    if (s_tready) begin
      tready_seen++;
      if (!busy || wea || load_done) tready_bad = 1'b1;
    end
  end

  // stimulus stream and expected outcome
  logic [31:0] bd[$];
  bit          bl[$];
  wr_t         exp_q[$];
  bit          exp_err, exp_rdy;
  logic [31:0] exp_last;
  int          exp_beats;

  task automatic mk(input int cnt, input int early_pos, input bit drop_last, input bit seq);
    bd.delete(); bl.delete();
    for (int i = 0; i < cnt*BEATS; i++) begin
      bd.push_back(seq ? 32'(i) : $urandom);
      bl.push_back((i == early_pos) || (i == cnt*BEATS-1 && !drop_last));
    end
  endtask

  task automatic model(input logic [31:0] base, input logic [31:0] cnt);
    logic [127:0] w;
    exp_q.delete(); exp_err = 0; exp_rdy = 0; exp_beats = 0; w = '0;
    exp_last = (cnt == 0) ? 32'd0 : base + cnt - 1;
    if (cnt == 0) return;
    if (longint'(base) + longint'(cnt) > DEPTH) begin exp_err = 1; return; end
    exp_rdy = 1;
    for (int g = 0; g < int'(cnt)*BEATS && g < bd.size(); g++) begin
      bit fin_beat;
      fin_beat = (g == int'(cnt)*BEATS - 1);
      exp_beats = g + 1;
      w[(g % BEATS)*32 +: 32] = bd[g];
      if (bl[g] && !fin_beat) begin exp_err = 1; return; end
      if (g % BEATS == BEATS-1) begin
        exp_q.push_back('{base + 32'(g / BEATS), w, 0});
        if (fin_beat && !bl[g]) exp_err = 1;
      end
    end
  endtask

  // vmode: 0 back-to-back, 1 toggling valid, 2 random valid
  task automatic run_load(input logic [31:0] base, input logic [31:0] cnt,
                          input int vmode, input int abort_at);
    int idx, k, st_cyc, hs_cyc;
    bit hs, fin, tog;
    model(base, cnt);
    got_q.delete(); done_n = 0; tready_seen = 0; tready_bad = 0;
    idx = 0; k = 0; hs = 0; tog = 1; hs_cyc = 0;
    @(posedge clk); #1;
    load_base = base; load_count = cnt; load_start = 1'b1;
    @(negedge clk); st_cyc = cyc;
    @(posedge clk); #1; load_start = 1'b0;
    @(negedge clk); fin = load_done;
    chk("last_addr", last_addr, exp_last);
    chk("busy_after_start", busy, 1);
    while (!fin && k < 2000) begin
      @(posedge clk); #1;
      if (hs) idx++;
      if (abort_at > 0 && idx >= abort_at) begin s_tvalid = 1'b0; return; end
      if (idx < bd.size()) begin
        s_tdata  = bd[idx];
        s_tlast  = bl[idx];
        s_tvalid = (vmode == 0) ? 1'b1 : (vmode == 1) ? tog : 1'($urandom);
      end else s_tvalid = 1'b0;
      tog = !tog;
      @(negedge clk);
      hs = s_tvalid && s_tready;
      if (hs) hs_cyc = cyc;
      fin = load_done; k++;
    end
    if (hs) idx++;
    chk("done_seen", fin, 1);
    @(posedge clk); #1; s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("done_pulses", done_n, 1);
    chk("load_err", load_err, exp_err);
    chk("busy_end", busy, 0);
    chk("beats_taken", idx, exp_beats);
    chk("tready_seen", tready_seen != 0, exp_rdy);
    chk("tready_outside_recv", tready_bad, 0);
    chk("num_writes", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk("wr_addr", got_q[i].a, exp_q[i].a);
      chk("wr_data", got_q[i].d, exp_q[i].d);
    end
    if (cnt != 0 && exp_q.size() == int'(cnt) && got_q.size() == int'(cnt)) begin
      chk("wea_latency", got_q[got_q.size()-1].c - hs_cyc, 1);
      chk("done_latency", done_cyc - got_q[got_q.size()-1].c, 1);
    end
    if (cnt == 0) chk("done_latency_zero", done_cyc - st_cyc, 1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ctrl"}, {wea, busy, s_tready, load_done, load_err}, 0);
    chk({tag, "_last_addr"}, last_addr, 0);
    chk({tag, "_addra"}, addra, 0);
    chk({tag, "_dina"}, dina, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    @(posedge clk); #1; reset_n = 1'b1;

    // sequential beats 0..7 into two instructions
    mk(2, -1, 0, 1);
    run_load(32'h10, 2, 0, 0);
    if (got_q.size() == 2) begin
      chk("case1_d0", got_q[0].d, 128'h00000003_00000002_00000001_00000000);
      chk("case1_d1", got_q[1].d, 128'h00000007_00000006_00000005_00000004);
    end else chk("case1_writes", got_q.size(), 2);
    run_load(32'h10, 2, 1, 0);

    // early tlast, then a clean load clears the error
    mk(2, 2, 0, 1);
    run_load(32'h10, 2, 0, 0);
    mk(2, -1, 0, 1);
    run_load(32'h10, 2, 2, 0);

    // zero count, range overflow, exact fit at the top, missing tlast
    run_load(32'h40, 0, 0, 0);
    mk(8, -1, 0, 0);
    run_load(32'd1020, 8, 0, 0);
    run_load(32'd1016, 8, 2, 0);
    mk(1, -1, 1, 0);
    run_load(32'h20, 1, 0, 0);

    // reset partway through a load, then repeat it
    mk(2, -1, 0, 1);
    run_load(32'h10, 2, 0, 5);
    reset_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk_reset_state("midload_reset");
    @(posedge clk); #1; reset_n = 1'b1;
    run_load(32'h10, 2, 0, 0);

    for (int t = 0; t < 12; t++) begin
      int cnt, early;
      cnt   = $urandom_range(0, 4);
      early = ($urandom_range(0, 3) == 0 && cnt > 0) ? $urandom_range(0, cnt*BEATS-2) : -1;
      mk(cnt, early, $urandom_range(0, 5) == 0, 0);
      run_load($urandom_range(0, DEPTH + 4), cnt, 2, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
endmodule
